// File: rtl/sudoku_checker_n.sv
// sudoku_checker_n
//   Stores an N^2 x N^2 Sudoku board loaded serially in row-major order and,
//   on command, scans it one cell per clock for duplicate digits.
//   Scan order: every row, then every column, then (optionally) every box.
//   The scan stops at the first duplicate found.
//
//   Optional feature macro: SUDOKU_BOX_CHECK_EN
//     defined   -> the box phase is compiled in (three phases, err_kind=3 possible)
//     undefined -> rows and columns only (scan length 2*SIDE^2)
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset (clears the board too)
//   in_valid     write in_value into the next cell
//   in_value     cell value, 0 = empty, 1..SIDE = digit, >SIDE stored as 0
//   check_start  start a scan (ignored while busy)
//   load_full    all SIDE^2 cells written
//   range_err    sticky: an out-of-range value was accepted
//   busy         scan in progress
//   done         last scan finished
//   err          last scan found a duplicate
//   err_kind     0 none, 1 row, 2 column, 3 box
//   err_unit     index of the failing row/column/box
module sudoku_checker_n #(
  parameter int BOX = 3,
  parameter int VW  = $clog2(BOX*BOX+1),
  parameter int IW  = $clog2(BOX*BOX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [VW-1:0] in_value,
  input  logic          check_start,
  output logic          load_full,
  output logic          range_err,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_kind,
  output logic [IW-1:0] err_unit
);

  localparam int SIDE  = BOX*BOX;
  localparam int NCELL = SIDE*SIDE;
  localparam int CW    = $clog2(NCELL+1);
  localparam int AW    = $clog2(NCELL);

  localparam logic [1:0]      PH_ROW   = 2'd0;
  localparam logic [1:0]      PH_COL   = 2'd1;
`ifdef SUDOKU_BOX_CHECK_EN
  localparam logic [1:0]      PH_BOX   = 2'd2;
  localparam logic [1:0]      LAST_PH  = 2'd2;
  localparam logic [IW-1:0]   BOX_LAST = IW'(BOX-1);
`else
  localparam logic [1:0]      LAST_PH  = 2'd1;
`endif
  localparam logic [IW-1:0]   IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0]   IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(SIDE-1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(NCELL);
  localparam logic [VW-1:0]   VAL_ZERO = {VW{1'b0}};
  localparam logic [VW-1:0]   VAL_ONE  = VW'(1);
  localparam logic [VW-1:0]   VAL_MAX  = VW'(SIDE);
  localparam logic [SIDE-1:0] MASK_ZERO = {SIDE{1'b0}};
  localparam logic [SIDE-1:0] MASK_ONE  = {{(SIDE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  logic [VW-1:0]   cells_r [NCELL];
  logic [CW-1:0]   cnt_r;
  logic            load_full_r, range_err_r;

  state_t          state_r, state_s;
  logic [1:0]      phase_r, phase_s;
  logic [IW-1:0]   unit_r, unit_s, idx_r, idx_s;
  logic [SIDE-1:0] mask_r, mask_s;
  logic            busy_r, busy_s, done_r, done_s, err_r, err_s;
  logic [1:0]      kind_r, kind_s;
  logic [IW-1:0]   eunit_r, eunit_s;
`ifdef SUDOKU_BOX_CHECK_EN
  // box row/col of the unit and row/col inside the box, kept as counters
  logic [IW-1:0]   brow_r, brow_s, bcol_r, bcol_s, irow_r, irow_s, icol_r, icol_s;
`endif

  logic [IW-1:0]   row_s, col_s;
  logic [AW-1:0]   addr_s;
  logic [VW-1:0]   val_s;
  logic [SIDE-1:0] bit_s, prev_s;
  logic            dup_s, last_cell_s;

  // Board load: serial row-major writes, so the linear address is the counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      load_full_r <= 1'b0;
      range_err_r <= 1'b0;
      for (int i = 0; i < NCELL; i++) begin
        cells_r[i] <= VAL_ZERO;
      end
    end else if (in_valid && !busy_r && !load_full_r) begin
      if (in_value > VAL_MAX) begin
        cells_r[AW'(cnt_r)] <= VAL_ZERO;
        range_err_r         <= 1'b1;
      end else begin
        cells_r[AW'(cnt_r)] <= in_value;
      end
      cnt_r       <= cnt_r + CNT_ONE;
      load_full_r <= ((cnt_r + CNT_ONE) == CNT_FULL);
    end
  end

  // Scan cursor to cell address, and the duplicate test against the unit mask
  always_comb begin
    row_s = unit_r;
    col_s = idx_r;
    case (phase_r)
      PH_ROW: begin
        row_s = unit_r;
        col_s = idx_r;
      end
      PH_COL: begin
        row_s = idx_r;
        col_s = unit_r;
      end
`ifdef SUDOKU_BOX_CHECK_EN
      PH_BOX: begin
        row_s = brow_r * IW'(BOX) + irow_r;
        col_s = bcol_r * IW'(BOX) + icol_r;
      end
`endif
      default: begin
        row_s = unit_r;
        col_s = idx_r;
      end
    endcase
    addr_s = AW'(row_s) * AW'(SIDE) + AW'(col_s);
    val_s  = cells_r[addr_s];
    if (val_s == VAL_ZERO) begin
      bit_s = MASK_ZERO;
    end else begin
      bit_s = MASK_ONE << (val_s - VAL_ONE);
    end
    // first cell of a unit sees an empty mask: no clear cycle between units
    if (idx_r == IDX_ZERO) begin
      prev_s = MASK_ZERO;
    end else begin
      prev_s = mask_r;
    end
    dup_s       = |(prev_s & bit_s);
    last_cell_s = (phase_r == LAST_PH) && (unit_r == IDX_LAST) && (idx_r == IDX_LAST);
  end

  // Next-state and next-output logic of the scan FSM
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    unit_s  = unit_r;
    idx_s   = idx_r;
    mask_s  = mask_r;
    busy_s  = busy_r;
    done_s  = done_r;
    err_s   = err_r;
    kind_s  = kind_r;
    eunit_s = eunit_r;
`ifdef SUDOKU_BOX_CHECK_EN
    brow_s  = brow_r;
    bcol_s  = bcol_r;
    irow_s  = irow_r;
    icol_s  = icol_r;
`endif
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (check_start) begin
          state_s = ST_SCAN;
          busy_s  = 1'b1;
          done_s  = 1'b0;
          err_s   = 1'b0;
          kind_s  = 2'd0;
          eunit_s = IDX_ZERO;
          phase_s = PH_ROW;
          unit_s  = IDX_ZERO;
          idx_s   = IDX_ZERO;
          mask_s  = MASK_ZERO;
`ifdef SUDOKU_BOX_CHECK_EN
          brow_s  = IDX_ZERO;
          bcol_s  = IDX_ZERO;
          irow_s  = IDX_ZERO;
          icol_s  = IDX_ZERO;
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_SCAN: begin
        if (dup_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          err_s   = 1'b1;
          kind_s  = phase_r + 2'd1;
          eunit_s = unit_r;
        end else if (last_cell_s) begin
          state_s = ST_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          mask_s  = prev_s | bit_s;
        end else begin
          mask_s = prev_s | bit_s;
          if (idx_r == IDX_LAST) begin
            idx_s = IDX_ZERO;
            if (unit_r == IDX_LAST) begin
              unit_s  = IDX_ZERO;
              phase_s = phase_r + 2'd1;
            end else begin
              unit_s = unit_r + IDX_ONE;
            end
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
`ifdef SUDOKU_BOX_CHECK_EN
          if (phase_r == PH_BOX) begin
            if (icol_r == BOX_LAST) begin
              icol_s = IDX_ZERO;
              if (irow_r == BOX_LAST) begin
                irow_s = IDX_ZERO;
                if (bcol_r == BOX_LAST) begin
                  bcol_s = IDX_ZERO;
                  brow_s = brow_r + IDX_ONE;
                end else begin
                  bcol_s = bcol_r + IDX_ONE;
                end
              end else begin
                irow_s = irow_r + IDX_ONE;
              end
            end else begin
              icol_s = icol_r + IDX_ONE;
            end
          end else begin
            icol_s = icol_r;
          end
`endif
        end
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Scan FSM state, cursor and registered result outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      phase_r <= PH_ROW;
      unit_r  <= IDX_ZERO;
      idx_r   <= IDX_ZERO;
      mask_r  <= MASK_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      kind_r  <= 2'd0;
      eunit_r <= IDX_ZERO;
`ifdef SUDOKU_BOX_CHECK_EN
      brow_r  <= IDX_ZERO;
      bcol_r  <= IDX_ZERO;
      irow_r  <= IDX_ZERO;
      icol_r  <= IDX_ZERO;
`endif
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      unit_r  <= unit_s;
      idx_r   <= idx_s;
      mask_r  <= mask_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      err_r   <= err_s;
      kind_r  <= kind_s;
      eunit_r <= eunit_s;
`ifdef SUDOKU_BOX_CHECK_EN
      brow_r  <= brow_s;
      bcol_r  <= bcol_s;
      irow_r  <= irow_s;
      icol_r  <= icol_s;
`endif
    end
  end

  assign load_full = load_full_r;
  assign range_err = range_err_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_kind  = kind_r;
  assign err_unit  = eunit_r;

endmodule

// File: tb/tb_sudoku_checker_n.sv
// Directed testbench for sudoku_checker_n: a BOX=3 instance and a BOX=2 instance.
module tb_sudoku_checker_n;

`ifdef SUDOKU_BOX_CHECK_EN
  localparam int NPH = 3;
`else
  localparam int NPH = 2;
`endif

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // BOX=3 instance
  logic       rst_n, in_valid, check_start;
  logic [3:0] in_value;
  logic       load_full, range_err, busy, done, err;
  logic [1:0] err_kind;
  logic [3:0] err_unit;

  // BOX=2 instance
  logic       rst2_n, in_valid2, check_start2;
  logic [2:0] in_value2;
  logic       load_full2, range_err2, busy2, done2, err2;
  logic [1:0] err_kind2;
  logic [1:0] err_unit2;

  int n_pass  = 0;
  int n_total = 0;
  int cyc;

  sudoku_checker_n #(.BOX(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_value(in_value),
    .check_start(check_start), .load_full(load_full), .range_err(range_err),
    .busy(busy), .done(done), .err(err), .err_kind(err_kind), .err_unit(err_unit)
  );

  sudoku_checker_n #(.BOX(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_value(in_value2),
    .check_start(check_start2), .load_full(load_full2), .range_err(range_err2),
    .busy(busy2), .done(done2), .err(err2), .err_kind(err_kind2), .err_unit(err_unit2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference 9x9 solution; modes plant specific faults
  function automatic int base9(input int r, input int c);
    return ((r*3 + r/3 + c) % 9) + 1;
  endfunction

  function automatic int g9(input int r, input int c, input int mode);
    int rr = r;
    int cc = c;
    if (mode == 1 && r == 4 && c == 7) cc = 2;          // row-4 duplicate
    if (mode == 2 && r == 0 && c == 3) cc = 4;          // swap (0,3)/(0,4)
    else if (mode == 2 && r == 0 && c == 4) cc = 3;
    if (mode == 3 && r == 2) rr = 3;                    // swap rows 2/3: box-only
    else if (mode == 3 && r == 3) rr = 2;
    return base9(rr, cc);
  endfunction

  function automatic int g4(input int r, input int c);
    return ((r*2 + r/2 + c) % 4) + 1;
  endfunction

  task automatic rst3();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic w3(input int v);
    in_valid = 1'b1;
    in_value = v[3:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic load9(input int mode);
    for (int i = 0; i < 81; i++) w3(g9(i/9, i%9, mode));
  endtask

  // Start a scan (optionally writing wv on the start edge), optionally poking
  // in_valid/check_start for the first ivc busy cycles; cyc = busy cycles.
  task automatic scan3(input int ivc, input int wv, output int cyc_o);
    check_start = 1'b1;
    if (wv > 0) begin
      in_valid = 1'b1;
      in_value = wv[3:0];
    end
    @(posedge clk); #1;
    check_start = 1'b0;
    in_valid    = 1'b0;
    cyc_o = 0;
    while (busy === 1'b1 && cyc_o < 2000) begin
      in_valid    = (cyc_o < ivc);
      check_start = (cyc_o < ivc);
      in_value    = 4'd1;
      cyc_o++;
      @(posedge clk); #1;
    end
    in_valid    = 1'b0;
    check_start = 1'b0;
  endtask

  task automatic w2(input int v);
    in_valid2 = 1'b1;
    in_value2 = v[2:0];
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic scan2(output int cyc_o);
    check_start2 = 1'b1;
    @(posedge clk); #1;
    check_start2 = 1'b0;
    cyc_o = 0;
    while (busy2 === 1'b1 && cyc_o < 500) begin
      cyc_o++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; check_start = 1'b0; in_value = 4'd0;
    rst2_n = 1'b0; in_valid2 = 1'b0; check_start2 = 1'b0; in_value2 = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_full", load_full, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_kind", err_kind, 0);
    chk("rst_err_unit", err_unit, 0);
    rst_n = 1'b1; rst2_n = 1'b1;

    // clean solved grid
    for (int i = 0; i < 81; i++) begin
      w3(g9(i/9, i%9, 0));
      if (i == 79) chk("full_after_80", load_full, 0);
    end
    chk("full_after_81", load_full, 1);
    scan3(0, 0, cyc);
    chk("clean_busy_cycles", cyc, NPH*81);
    chk("clean_done", done, 1);
    chk("clean_err", err, 0);
    chk("clean_kind", err_kind, 0);

    // row duplicate at (4,7)
    rst3();
    load9(1);
    scan3(0, 0, cyc);
    chk("row_cycles", cyc, 44);
    chk("row_err", err, 1);
    chk("row_kind", err_kind, 1);
    chk("row_unit", err_unit, 4);
    chk("row_done", done, 1);

    // column-3 duplicate, rows valid
    rst3();
    load9(2);
    scan3(0, 0, cyc);
    chk("col_cycles", cyc, 112);
    chk("col_err", err, 1);
    chk("col_kind", err_kind, 2);
    chk("col_unit", err_unit, 3);

    // box-only fault
    rst3();
    load9(3);
    scan3(0, 0, cyc);
    chk("box9_cycles", cyc, (NPH == 3) ? 169 : 162);
    chk("box9_err", err, (NPH == 3) ? 1 : 0);
    chk("box9_kind", err_kind, (NPH == 3) ? 3 : 0);
    chk("box9_unit", err_unit, 0);

    // partial load with an out-of-range value; pokes during busy are ignored
    rst3();
    for (int i = 0; i < 40; i++) w3((i == 5) ? 12 : g9(i/9, i%9, 0));
    chk("range_err_set", range_err, 1);
    chk("partial_not_full", load_full, 0);
    scan3(10, 0, cyc);
    chk("partial_cycles", cyc, NPH*81);
    chk("partial_err", err, 0);
    for (int i = 0; i < 40; i++) w3(0);
    chk("cnt_held_80", load_full, 0);
    w3(0);
    chk("cnt_held_81", load_full, 1);
    chk("range_err_sticky", range_err, 1);

    // reset in the middle of a scan
    rst3();
    load9(0);
    check_start = 1'b1;
    @(posedge clk); #1;
    check_start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_full", load_full, 0);

    // 82nd write must not wrap into cell 0 (value 2 would duplicate row 0)
    load9(0);
    w3(2);
    chk("w82_full", load_full, 1);
    scan3(0, 0, cyc);
    chk("w82_err", err, 0);
    chk("w82_cycles", cyc, NPH*81);

    // write and start on the same edge: scan sees the new cell
    rst3();
    w3(5);
    scan3(0, 5, cyc);
    chk("same_cycle_cycles", cyc, 2);
    chk("same_cycle_err", err, 1);
    chk("same_cycle_kind", err_kind, 1);
    chk("same_cycle_unit", err_unit, 0);

    // BOX=2: clean 4x4 solution
    for (int i = 0; i < 16; i++) w2(g4(i/4, i%4));
    chk("b2_full", load_full2, 1);
    scan2(cyc);
    chk("b2_clean_cycles", cyc, NPH*16);
    chk("b2_clean_err", err2, 0);
    chk("b2_clean_done", done2, 1);

    // BOX=2: only (2,0)=1 and (3,1)=1 -> box 2 duplicate only
    rst2_n = 1'b0;
    @(posedge clk); #1;
    rst2_n = 1'b1;
    for (int i = 0; i < 14; i++) w2((i == 8 || i == 13) ? 1 : 0);
    scan2(cyc);
    chk("b2_box_cycles", cyc, (NPH == 3) ? 44 : 32);
    chk("b2_box_err", err2, (NPH == 3) ? 1 : 0);
    chk("b2_box_kind", err_kind2, (NPH == 3) ? 3 : 0);
    chk("b2_box_unit", err_unit2, (NPH == 3) ? 2 : 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sudoku_checker_n.md
# sudoku_checker_n

Parametrised Sudoku board store and rule checker for an N²×N² grid. It sits behind the pin-level input decoder and loads cells serially in row-major order. On command, it scans the stored board for duplicates in every row, every column and (optionally) every box, one cell per clock. The scan stops at the first violation, and the block reports which rule and which unit failed.

## Interface
Parameters:
- BOX, default 3: box edge length. The grid side is SIDE = BOX*BOX (9 by default). Legal range is 2..4.
- VW, default $clog2(BOX*BOX+1): width of a cell value (4 for BOX=3).
- IW, default $clog2(BOX*BOX): width of a row/column/box index (4 for BOX=3).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low. Clock is clk.
- in_valid, in, 1: writes in_value to the next cell.
- in_value, in, VW: cell value. 0 means empty; 1..SIDE are legal digits.
- check_start, in, 1: starts a scan. Honoured only when not busy.
- load_full, out, 1: all SIDE² cells have been written.
- range_err, out, 1: sticky. Set when any in_value > SIDE was accepted.
- busy, out, 1: a scan is in progress.
- done, out, 1: the last scan has finished.
- err, out, 1: the last scan found a duplicate.
- err_kind, out, 2: 0 none, 1 row, 2 column, 3 box.
- err_unit, out, IW: index of the failing row, column or box.

## Operation
- Storage: SIDE² cells of VW bits each, plus a load counter of $clog2(SIDE²+1) bits.
- Load:
  - When in_valid=1, busy=0 and load_full=0, the value is written to cell (cnt / SIDE, cnt % SIDE) and the counter increments.
  - When the counter reaches SIDE², load_full rises.
  - Further in_valid is ignored (no wrap-around).
  - in_valid while busy=1 is ignored and the counter holds.
  - A value greater than SIDE is stored as 0 and sets range_err.
- FSM states: IDLE, SCAN, DONE.
  - IDLE or DONE, with check_start=1: go to SCAN. The cursor, mask, done, err, err_kind and err_unit are cleared.
  - SCAN, one cell per cycle, in phase order:
    - ROW phase: row outer, column inner.
    - COL phase: column outer, row inner.
    - BOX phase: box b outer, in-box index i inner. The cell is row (b/BOX)*BOX + i/BOX, column (b%BOX)*BOX + i%BOX. Implement this with nested counters, not dividers.
  - Per cell:
    - Use a SIDE-bit used-mask. The mask is treated as zero on the first cell of each unit, so there is no bubble cycle between units.
    - A value of 0 is skipped.
    - If bit (v-1) is already set, the cell is a duplicate. Go to DONE with err=1, err_kind set to the phase and err_unit set to the unit index.
    - Otherwise set bit (v-1).
  - SCAN, after the last cell of the last phase: go to DONE with err=0 and err_kind=0.
  - DONE: done=1 and the error outputs hold until the next check_start or reset.
- A scan may start before load_full is set. Unwritten cells read as 0.

## Timing
- Reset values: cells 0, counter 0, load_full 0, range_err 0, busy 0, done 0, err 0, err_kind 0, err_unit 0. State is IDLE.
- Reset during a scan aborts it the same edge. The board contents are lost.
- busy=1 from the edge that accepts check_start.
- Clean scan: busy is high for exactly P*SIDE² cycles. P=3, or 2 without the box check (243 or 162 cycles for BOX=3). done rises on the edge that clears busy.
- Duplicate at scan cycle k (0-based): done=1 and err=1 after edge k+1, and busy falls on that same edge.
- check_start while busy=1 is ignored.
- in_valid and check_start in the same IDLE cycle: the write commits on that edge and the scan sees the new value.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- SUDOKU_BOX_CHECK_EN defined: the BOX phase is compiled in. There are three phases, and err_kind=3 is possible.
- Not defined: the BOX phase logic is removed. Scan length is 2*SIDE², and err_kind is never 3.

## Test plan
- BOX=3: load a valid solved grid (81 writes), then check_start. Expect load_full=1 after write 81, busy for 243 cycles, then done=1, err=0, err_kind=0.
- Same grid with cell (4,7) changed to equal cell (4,2). Expect err=1, err_kind=1, err_unit=4, done at scan cycle 4*9+7+1=44.
- Grid with rows valid but a column-3 duplicate. Expect err_kind=2, err_unit=3. Build without the macro: the same box-only fault (rows and columns valid) gives err=0 after 162 cycles.
- Load 40 cells including value 12, then scan. Expect range_err=1, that cell read as 0, and load_full=0. Then in_valid during busy: the counter stays at 40.
- Assert rst_n=0 at scan cycle 100. Expect busy=0, done=0, load_full=0 next cycle. An 82nd write after a full load is ignored.
- BOX=2: load the 4×4 solution, then scan. Expect busy for 48 cycles and err=0. A box-only fault gives err_kind=3 with the correct err_unit.
